gru_seq_ctrl: RTL
=================

GRU_SEQ_CTRL -- requirements
Module: gru_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the signed fixed-point word width of X, h and cell ports.
REQ-002 SHALL have parameter FRACT_WIDTH, default 5, the fraction bits; carried for documentation only, no arithmetic depends on it.
REQ-003 SHALL have parameter SEQ_LEN_W, default 8, the width of the sequence-length and step counters.
REQ-004 SHALL have parameter CELL_LAT, default 1, range 1..15, the cycles allowed for the combinational cell to settle.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk input 1 (rising edge); rst input 1 (async, active-high).
REQ-006 SHALL have port start, input, 1 bit, a request to begin a sequence (sampled in IDLE only).
REQ-007 SHALL have port seq_len, input, SEQ_LEN_W bits, the number of timesteps (unsigned), latched on accepted start.
REQ-008 SHALL have port init_sel, input, 1 bit: 0 selects initial h = 0; 1 selects h_init; latched on accepted start.
REQ-009 SHALL have port h_init, input, DATA_WIDTH bits, the signed initial hidden state, latched on accepted start.
REQ-010 SHALL have ports x_valid (input, 1), x_data (input, DATA_WIDTH) and x_ready (output, 1), forming the input timestep stream.
REQ-011 SHALL have ports cell_x (output, DATA_WIDTH), cell_h (output, DATA_WIDTH) and cell_h_out (input, DATA_WIDTH), connecting to the external GRU cell's X, h_in and h_out.
REQ-012 SHALL have ports y_valid (output, 1), y_data (output, DATA_WIDTH) and y_ready (input, 1), forming the per-step hidden-state output stream.
REQ-013 SHALL have ports busy (output, 1), done (output, 1-cycle pulse) and h_final (output, DATA_WIDTH, the last hidden state).

Function
REQ-014 SHALL implement the FSM IDLE -> WAIT_X -> SETTLE -> EMIT -> (WAIT_X | DONE) -> IDLE, with all state registered.
REQ-015 In IDLE with start=1 and seq_len!=0: latch seq_len, load h_reg (0 or h_init per init_sel), clear step counter, and go to WAIT_X.
REQ-016 In IDLE with start=1 and seq_len==0: go to DONE, set h_final to the selected initial h, and emit no y beats.
REQ-017 x_ready SHALL be 1 only in WAIT_X.
- On x_valid&x_ready: latch x_data into x_reg, clear the settle counter, and go to SETTLE.
REQ-018 cell_x SHALL equal x_reg and cell_h SHALL equal h_reg at all times; both are direct register outputs.
REQ-019 SETTLE SHALL last exactly CELL_LAT cycles; on its final cycle, register cell_h_out into h_reg and y_data, then go to EMIT.
REQ-020 In EMIT, y_valid SHALL be 1 and y_data held stable until y_ready=1; on handshake, increment the step counter.
- If the step counter was seq_len-1, go to DONE; else go to WAIT_X.
REQ-021 DONE SHALL last one cycle: done=1, h_final=h_reg, then go to IDLE.
- h_final SHALL hold its value until the next DONE or reset.
REQ-022 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy=1.
REQ-023 The step counter SHALL be SEQ_LEN_W bits, compare exactly and never wrap; seq_len = 2^SEQ_LEN_W-1 SHALL run all 255 steps at default width.
REQ-024 Minimum per-step latency SHALL be 1 (accept) + CELL_LAT + 1 (EMIT) cycles, with x_valid and y_ready held high.
REQ-025 No back-to-back overlap: the next X SHALL NOT be accepted before the current y handshake completes.

Reset
REQ-026 On rst=1, the block SHALL enter IDLE immediately.
- Outputs forced: x_ready=0, y_valid=0, done=0, busy=0.
- Registers cleared: y_data=0, h_final=0, cell_x=0, cell_h=0, step and settle counters=0.
REQ-027 Reset asserted mid-sequence SHALL abort it without a done pulse; the first start after release begins a fresh sequence.

Verification (bench cell stub: cell_h_out = cell_x + cell_h, 8-bit wrap)
REQ-028 start, seq_len=3, init_sel=0, X=1,2,3, y_ready=1 -> y_data=1,3,6; done pulse; h_final=6; 3 steps of 3 cycles each (CELL_LAT=1).
REQ-029 init_sel=1, h_init=-4 (8'hFC), seq_len=1, X=5 -> y_data=1, h_final=1.
REQ-030 seq_len=0, init_sel=1, h_init=8'h22 -> done one cycle after start, no y_valid, h_final=8'h22.
REQ-031 y_ready held 0 for 5 cycles in EMIT -> y_valid and y_data stable throughout, x_ready=0, start pulse ignored.
REQ-032 rst asserted during SETTLE of step 2 -> all outputs immediately at reset values, no done; a new seq_len=2 run gives correct results.
REQ-033 CELL_LAT=3, x_valid gapped by 2 idle cycles -> each step takes exactly 5 cycles after X acceptance, results unchanged.

Source files
------------

// File: rtl/gru_seq_ctrl.sv
// gru_seq_ctrl -- sequences an external combinational GRU cell over a stream
// of timesteps. Each accepted X is held in x_reg while the cell settles for
// CELL_LAT cycles. The cell result then becomes the new hidden state and is
// offered on the y stream. After seq_len steps the final hidden state appears
// on h_final together with a one-cycle done pulse.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, seq_len,          sequence request; the length, initial-state select
//   init_sel, h_init         and initial hidden state are latched when accepted
//   x_valid, x_data, x_ready input timestep stream (x_ready only in WAIT_X)
//   cell_x, cell_h           registered X and h_in driven to the GRU cell
//   cell_h_out               GRU cell h_out, sampled on the last settle cycle
//   y_valid, y_data, y_ready per-step hidden-state output stream
//   busy, done, h_final      status, end-of-sequence pulse, last hidden state
module gru_seq_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRACT_WIDTH = 5,
  parameter int SEQ_LEN_W   = 8,
  parameter int CELL_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEQ_LEN_W-1:0]  seq_len,
  input  logic                  init_sel,
  input  logic [DATA_WIDTH-1:0] h_init,
  input  logic                  x_valid,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_ready,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_h,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  y_valid,
  output logic [DATA_WIDTH-1:0] y_data,
  input  logic                  y_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] h_final
);

  // The fraction position is only meaningful to the cell; this block moves
  // words around unchanged. These empty guards document the legal ranges.
  if (FRACT_WIDTH < 0 || FRACT_WIDTH >= DATA_WIDTH) begin : g_fract_out_of_range
  end
  if (CELL_LAT < 1 || CELL_LAT > 15) begin : g_cell_lat_out_of_range
  end

  localparam logic [3:0]           SETTLE_LAST = 4'(CELL_LAT - 1);
  localparam logic [3:0]           SETTLE_ONE  = 4'd1;
  localparam logic [SEQ_LEN_W-1:0] STEP_ONE    = {{(SEQ_LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_X = 3'd1,
    S_SETTLE = 3'd2,
    S_EMIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                        state_q,   state_d;
  logic [SEQ_LEN_W-1:0]          seq_len_q, seq_len_d;
  logic [SEQ_LEN_W-1:0]          step_q,    step_d;
  logic [3:0]                    settle_q,  settle_d;
  logic signed [DATA_WIDTH-1:0]  x_q,       x_d;
  logic signed [DATA_WIDTH-1:0]  h_q,       h_d;
  logic signed [DATA_WIDTH-1:0]  y_data_q,  y_data_d;
  logic signed [DATA_WIDTH-1:0]  h_final_q, h_final_d;
  logic                          x_ready_q, x_ready_d;
  logic                          y_valid_q, y_valid_d;
  logic                          busy_q,    busy_d;
  logic                          done_q,    done_d;

  always_comb begin
    state_d   = state_q;
    seq_len_d = seq_len_q;
    step_d    = step_q;
    settle_d  = settle_q;
    x_d       = x_q;
    h_d       = h_q;
    y_data_d  = y_data_q;
    h_final_d = h_final_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seq_len_d = seq_len;
          h_d       = init_sel ? h_init : '0;
          step_d    = '0;
          // A zero-length request still reports the initial state via DONE.
          state_d   = (seq_len == '0) ? S_DONE : S_WAIT_X;
        end
      end
      S_WAIT_X: begin
        if (x_valid) begin
          x_d      = x_data;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          h_d      = cell_h_out;
          y_data_d = cell_h_out;
          state_d  = S_EMIT;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end
      S_EMIT: begin
        if (y_ready) begin
          step_d  = step_q + STEP_ONE;
          // Exact compare against seq_len-1 (seq_len is never 0 here), so a
          // full-scale length runs to the end without the counter wrapping.
          state_d = (step_q == seq_len_q - STEP_ONE) ? S_DONE : S_WAIT_X;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // h_final is updated on entry to DONE so it is valid alongside the pulse.
    if (state_d == S_DONE && state_q != S_DONE) begin
      h_final_d = h_d;
    end

    // Handshake/status outputs are registered copies of the next state.
    x_ready_d = (state_d == S_WAIT_X);
    y_valid_d = (state_d == S_EMIT);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      seq_len_q <= '0;
      step_q    <= '0;
      settle_q  <= '0;
      x_q       <= '0;
      h_q       <= '0;
      y_data_q  <= '0;
      h_final_q <= '0;
      x_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_len_q <= seq_len_d;
      step_q    <= step_d;
      settle_q  <= settle_d;
      x_q       <= x_d;
      h_q       <= h_d;
      y_data_q  <= y_data_d;
      h_final_q <= h_final_d;
      x_ready_q <= x_ready_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x_ready = x_ready_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign y_data  = y_data_q;
  assign h_final = h_final_q;
  assign cell_x  = x_q;
  assign cell_h  = h_q;

endmodule
